mux4to1_rr_stream: RTL and testbench
====================================

# mux4to1_rr_stream

Four-channel to one-channel stream merger: the gathering counterpart to the team's 1:4 demultiplexer. Each cycle it picks one requesting input channel by round-robin, registers that beat into a single output stage, and tags it with the 2-bit channel index. A downstream 1:4 demux can use the tag directly as its select lines to route the beat back to channel y0..y3. Sits between four producer streams and one shared consumer. Valid/ready handshake on every side.

## Interface
- WIDTH, 8, data bits per beat.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  per-channel beat valid; bit i = channel i.
- in_data  input  4*WIDTH  packed channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_last  input  4  per-channel end-of-packet marker.
- in_ready  output  4  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered beat data.
- out_sel  output  2  source channel index; out_sel[1] is s0 and out_sel[0] is s1 of the matching demux.
- out_last  output  1  registered copy of the accepted beat's in_last.

## Operation
- Single output register stage. load = !out_valid || out_ready.
- Eligible set E = in_valid, masked to the locked channel when a lock is active (see Configuration).
- Grant g: the first set bit of E, scanning upward from ptr modulo 4 (ptr, ptr+1, ...).
- in_ready[i] = load && (g == i) && E[i]. Every in_ready bit is 0 when E is empty or load is 0.
- An input transfer happens on a cycle where in_valid[g] && in_ready[g]. On that clock edge:
  - out_data <= data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - ptr <= g+1 mod 4 (wraps from 3 to 0).
- If out_ready && out_valid and no input transfer happens, out_valid <= 0. Data, sel and last hold their values.
- Simultaneous drain and load: the new beat replaces the old one, with no bubble.
- in_ready depends combinationally on in_valid, out_valid, out_ready, ptr and lock. A producer must not make in_valid depend on in_ready.
- A producer holds in_valid and its data stable until accepted. The block does not check this.

## Timing
- Latency: 1 cycle, from the input transfer edge to out_valid.
- Throughput: 1 beat per cycle while out_ready stays high.
- Fairness: with all four channels continuously valid and no lock, grants rotate 0,1,2,3,0,...
- Backpressure: while out_valid && !out_ready, every in_ready bit is 0 and the output holds.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, lock cleared. in_ready is 0 during any cycle with rst high.
- Reset in mid-operation:
  - The pending output beat is dropped.
  - Any lock is released.
  - After rst falls, arbitration restarts at channel 0.

## Configuration
- MUX4TO1_PKT_LOCK_EN defined:
  - A transfer with in_last=0 locks arbitration to that channel.
  - While locked, only that channel is eligible. ptr still updates but has no effect.
  - A transfer with in_last=1 clears the lock.
  - Result: packets are never interleaved on the output.
- MUX4TO1_PKT_LOCK_EN undefined:
  - No lock state. Arbitration is per beat.
  - in_last is only carried to out_last.

## Structure
- Package mux4to1_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - The rotate-and-priority-encode function used for the round-robin scan.
- Sub-module rr_arb4: combinational grant from E and ptr. Outputs are a one-hot grant and a valid flag. The lock mask is applied before E enters rr_arb4.
- The top level holds the output register, ptr and the lock register.

## Test plan
- Reset, then a single beat: in_valid=4'b0100, data2=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, out_sel=2'b10.
- All channels valid with data i=8'h10+i, out_ready=1 -> outputs 10,11,12,13,10 on consecutive cycles with out_sel 0,1,2,3,0.
- Backpressure: out_ready=0 for 3 cycles while a beat is held -> in_ready=0, and out_data and out_sel stay constant. When out_ready rises, the next grant follows on the same cycle.
- Wrap-around: ptr=3 after a grant on channel 2, in_valid=4'b0001 -> channel 0 granted, then ptr=1.
- Lock (macro on): channel 1 sends a 3-beat packet with last on the third beat while channels 0 and 2 stay valid -> output sel is 1,1,1, then 2. Macro off -> sel is 1,2,0,1,...
- Reset while out_valid=1 and a lock is active -> the next cycle has out_valid=0 and all outputs 0. The first grant after reset goes to the lowest valid channel.

Source files
------------

// File: rtl/mux4to1_pkg.sv
// rtl/mux4to1_pkg.sv - shared constants and round-robin pick function for the 4:1 stream merger
//
// Purpose : channel count, select width and the rotate/priority-encode helper
//           used by rr_arb4.
// Ports   : none (package).
package mux4to1_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Rotate the request vector so bit ptr lands at position 0, take the lowest
  // set bit, then rotate the one-hot result back into channel order.
  function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [SEL_W-1:0]  ptr);
    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [NUM_CH-1:0]   pick;
    logic                found;
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_CH-1:0];
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    dbl = {pick, pick} << ptr;
    return dbl[2*NUM_CH-1:NUM_CH];
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin grant
//
// Purpose : one-hot grant to the first requester at or above ptr (mod 4).
// Ports   : req_i       eligible requests (already lock-masked)
//           ptr_i       highest-priority channel this cycle
//           gnt_o       one-hot grant, zero when req_i is empty
//           gnt_valid_o at least one request present
module rr_arb4
  import mux4to1_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic              gnt_valid_o
);

  assign gnt_o       = rr_pick(req_i, ptr_i);
  assign gnt_valid_o = |req_i;

endmodule

// File: rtl/mux4to1_rr_stream.sv
// rtl/mux4to1_rr_stream.sv - 4:1 round-robin stream merger with one registered output stage
//
// Purpose : merges four valid/ready producer streams into one, tagging each
//           beat with its source channel index in out_sel.
// Option  : MUX4TO1_PKT_LOCK_EN - when defined, a beat with in_last=0 locks
//           arbitration to its channel until that channel sends in_last=1.
// Ports   : clk, rst (sync, active high)
//           in_valid/in_data/in_last/in_ready  four packed producer channels
//           out_valid/out_data/out_sel/out_last/out_ready  merged consumer stream
module mux4to1_rr_stream
  import mux4to1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic              out_last_q,  out_last_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  logic              load;
  logic              xfer;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic              gnt_valid;
  logic [SEL_W-1:0]  g_idx;

`ifdef MUX4TO1_PKT_LOCK_EN
  logic lock_q, lock_d;

  // While locked, every accepted beat came from the locked channel, so the
  // output tag already names it; no separate lock-channel register is needed.
  always_comb begin
    elig = in_valid;
    if (lock_q) begin
      elig = in_valid & ({{(NUM_CH-1){1'b0}}, 1'b1} << out_sel_q);
    end
  end
`else
  assign elig = in_valid;
`endif

  rr_arb4 u_arb (
    .req_i       (elig),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) g_idx = SEL_W'(i);
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign xfer     = gnt_valid && load && !rst;
  assign in_ready = xfer ? gnt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
`ifdef MUX4TO1_PKT_LOCK_EN
    lock_d      = lock_q;
`endif
    if (xfer) begin
      // A draining beat is simply overwritten, so drain+load has no bubble.
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(g_idx)*WIDTH +: WIDTH];
      out_sel_d   = g_idx;
      out_last_d  = in_last[g_idx];
      ptr_d       = g_idx + 2'd1;
`ifdef MUX4TO1_PKT_LOCK_EN
      lock_d      = !in_last[g_idx];
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
`ifdef MUX4TO1_PKT_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
`ifdef MUX4TO1_PKT_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux4to1_rr_stream.sv
// tb/tb_mux4to1_rr_stream.sv - self-checking bench for the 4:1 round-robin stream merger
module tb_mux4to1_rr_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;

  always #5 clk = ~clk;

  mux4to1_rr_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: arbitration pointer, lock, and the single output slot.
  int         m_ptr = 0;
  bit         m_lock = 0;
  int         m_lock_ch = 0;
  logic       m_valid = 0;
  logic [7:0] m_data = 0;
  logic [1:0] m_sel = 0;
  logic       m_last = 0;

  logic [3:0] obs_ready;
  logic [3:0] exp_ready;

  // One clock: drive at negedge, sample in_ready just after, advance the model
  // at posedge, and leave the outputs settled #1 after the edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] l, input logic ordy);
    logic [3:0] e;
    int g;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    obs_ready = in_ready;
    g = -1;
    e = v;
`ifdef MUX4TO1_PKT_LOCK_EN
    if (m_lock) e = v & (4'b0001 << m_lock_ch);
`endif
    if (!r && (!m_valid || ordy)) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && e[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_lock = 0; m_lock_ch = 0;
      m_valid = 0; m_data = 0; m_sel = 0; m_last = 0;
    end else if (g >= 0) begin
      m_valid = 1; m_data = d[g*8 +: 8]; m_sel = 2'(g); m_last = l[g];
      m_ptr = (g + 1) % 4; m_lock = !l[g]; m_lock_ch = g;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'hF, $urandom, 4'h0, 1'b1);
      checks++;
      if (obs_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready: got %b expected 0000", obs_ready);
      end
      checks++;
      if ({out_valid, out_sel, out_last, out_data} !== 12'h000) begin
        errors++; $display("FAIL reset_out: got v%b s%0d l%b d%h expected all 0",
                           out_valid, out_sel, out_last, out_data);
      end
    end
  endtask

  task automatic test_single();
    step(1'b0, 4'b0100, 32'h00A5_0000, 4'b0100, 1'b1);
    checks++;
    if (obs_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b expected 0100", obs_ready);
    end
    checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'b10, 8'hA5}) begin
      errors++; $display("FAIL single_out: got v%b s%0d d%h expected v1 s2 da5",
                         out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 4'b0001, 32'h0000_003C, 4'b0001, 1'b1);
    checks++;
    if (obs_ready !== 4'b0001 || out_sel !== 2'd0 || out_data !== 8'h3C) begin
      errors++; $display("FAIL wrap_grant0: got r%b s%0d d%h expected r0001 s0 d3c",
                         obs_ready, out_sel, out_data);
    end
    step(1'b0, 4'b1111, 32'h4443_4241, 4'b1111, 1'b1);
    checks++;
    if (obs_ready !== 4'b0010 || out_sel !== 2'd1) begin
      errors++; $display("FAIL wrap_ptr1: got r%b s%0d expected r0010 s1", obs_ready, out_sel);
    end
  endtask

  task automatic test_rotate();
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 32'h1312_1110, 4'b1111, 1'b1);
      checks++;
      if (obs_ready !== 4'(1 << (i % 4)) || out_valid !== 1'b1 ||
          out_sel !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
        errors++; $display("FAIL rotate_%0d: got r%b v%b s%0d d%h expected s%0d d%h",
                           i, obs_ready, out_valid, out_sel, out_data, i % 4, 8'h10 + i % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    logic [1:0] held_s;
    held_d = m_data;
    held_s = m_sel;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 32'h1312_1110, 4'b1111, 1'b0);
      checks++;
      if (obs_ready !== 4'b0000 || out_valid !== 1'b1 ||
          out_data !== held_d || out_sel !== held_s) begin
        errors++; $display("FAIL bp_hold_%0d: got r%b v%b s%0d d%h expected r0000 v1 s%0d d%h",
                           i, obs_ready, out_valid, out_sel, out_data, held_s, held_d);
      end
    end
    step(1'b0, 4'b1111, 32'h1312_1110, 4'b1111, 1'b1);
    checks++;
    if (obs_ready !== 4'b0010 || out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin
      errors++; $display("FAIL bp_release: got r%b v%b s%0d d%h expected r0010 v1 s1 d11",
                         obs_ready, out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_lock();
    int ch1_beats;
    logic [1:0] exp_sel [4];
`ifdef MUX4TO1_PKT_LOCK_EN
    exp_sel = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
    exp_sel = '{2'd1, 2'd2, 2'd0, 2'd1};
`endif
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b1);
    step(1'b0, 4'b0001, 32'h0000_0001, 4'b0001, 1'b1);
    ch1_beats = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0111, {8'h00, 8'h20, 8'(8'h30 + ch1_beats), 8'h40},
           {1'b1, 1'b1, (ch1_beats == 2), 1'b1}, 1'b1);
      if (exp_ready[1]) ch1_beats++;
      checks++;
      if (out_sel !== exp_sel[i] || out_sel !== m_sel || out_last !== m_last) begin
        errors++; $display("FAIL lock_seq_%0d: got s%0d l%b expected s%0d l%b",
                           i, out_sel, out_last, exp_sel[i], m_last);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b1);
    step(1'b0, 4'b0010, 32'h0000_7700, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    checks++;
    if (obs_ready !== 4'b0000 || {out_valid, out_sel, out_last, out_data} !== 12'h000) begin
      errors++; $display("FAIL rstmid_clear: got r%b v%b s%0d l%b d%h expected all 0",
                         obs_ready, out_valid, out_sel, out_last, out_data);
    end
    step(1'b0, 4'b0110, 32'h0000_5500, 4'b0110, 1'b1);
    checks++;
    if (obs_ready !== 4'b0010 || out_sel !== 2'd1 || out_data !== 8'h55) begin
      errors++; $display("FAIL rstmid_first: got r%b s%0d d%h expected r0010 s1 d55",
                         obs_ready, out_sel, out_data);
    end
  endtask

  task automatic test_random();
    logic [3:0]  v, l, hold;
    logic [31:0] d;
    logic        r;
    v = '0; l = '0; d = '0; hold = '0;
    step(1'b1, 4'h0, 32'h0, 4'h0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!hold[c]) begin
          v[c] = ($urandom_range(0, 1) == 1);
          d[c*8 +: 8] = 8'($urandom);
          l[c] = ($urandom_range(0, 2) == 0);
          hold[c] = v[c];
        end
      end
      r = ($urandom_range(0, 63) == 0);
      step(r, v, d, l, ($urandom_range(0, 3) != 0));
      if (r) hold = '0;
      else hold = hold & ~exp_ready;
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready_%0d: got %b expected %b", n, obs_ready, exp_ready);
      end
      checks++;
      if ({out_valid, out_sel, out_last, out_data} !== {m_valid, m_sel, m_last, m_data}) begin
        errors++; $display("FAIL rand_out_%0d: got v%b s%0d l%b d%h expected v%b s%0d l%b d%h",
                           n, out_valid, out_sel, out_last, out_data,
                           m_valid, m_sel, m_last, m_data);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_rotate();
    test_backpressure();
    test_lock();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
